// File: rtl/timer_regs.sv
// Machine timer register block: 64-bit prescaled counter, 64-bit compare,
// sticky pending flag and level interrupt, with a coherent LO/HI read path.
module timer_regs #(
   parameter int          PRESC_W = 16,
   parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr,
   input  logic        i_rd,
   input  logic        i_cs,
   input  logic [2:0]  i_addr,
   input  logic [31:0] i_data_in,
   output logic [31:0] o_data_out,
   output logic        o_irq
);

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_PRESC   = 3'd1;
   localparam logic [2:0] A_MTIME_L = 3'd2;
   localparam logic [2:0] A_MTIME_H = 3'd3;
   localparam logic [2:0] A_CMP_L   = 3'd4;
   localparam logic [2:0] A_CMP_H   = 3'd5;

   logic               r_en;
   logic               r_ie;
   logic               r_per;
   logic               r_pend;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] r_pcnt;
   logic [63:0]        r_mtime;
   logic [63:0]        r_cmp;
   logic [31:0]        r_hi_snap;
   logic [31:0]        r_data_out;
   logic               r_irq;

   logic               w_we;
   logic               w_re;
   logic               w_match;
   logic               w_tick;
   logic [PRESC_W-1:0] w_pcnt_nxt;
   logic [63:0]        w_mtime_nxt;
   logic               w_pend_nxt;
   logic               w_ie_nxt;
   logic [31:0]        w_rdata;

   // Next-state for counter, prescaler, pending flag, plus the read mux.
   always_comb begin
      w_we    = i_cs & i_wr;
      w_re    = i_cs & i_rd;
      w_match = (r_mtime >= r_cmp);
      w_tick  = r_en && (r_pcnt == '0);

      w_pcnt_nxt = r_pcnt;
      if (w_we && i_addr == A_PRESC)
         w_pcnt_nxt = i_data_in[PRESC_W-1:0];
      else if (r_en)
         w_pcnt_nxt = w_tick ? r_presc : r_pcnt - 1'b1;

      // A software write replaces only its half; the tick is dropped entirely.
      w_mtime_nxt = r_mtime;
      if (w_we && i_addr == A_MTIME_L)
         w_mtime_nxt = {r_mtime[63:32], i_data_in};
      else if (w_we && i_addr == A_MTIME_H)
         w_mtime_nxt = {i_data_in, r_mtime[31:0]};
      else if (w_tick)
         w_mtime_nxt = (r_per && w_match) ? 64'd0 : r_mtime + 64'd1;

      // Set beats write-1-to-clear when both happen in the same cycle.
      w_pend_nxt = r_pend;
      if (w_we && i_addr == A_CTRL && i_data_in[3])
         w_pend_nxt = 1'b0;
      if (w_match)
         w_pend_nxt = 1'b1;

      w_ie_nxt = (w_we && i_addr == A_CTRL) ? i_data_in[1] : r_ie;

      case (i_addr)
         A_CTRL:    w_rdata = {28'd0, r_pend, r_per, r_ie, r_en};
         A_PRESC:   w_rdata = 32'(r_presc);
         A_MTIME_L: w_rdata = r_mtime[31:0];
         A_MTIME_H: w_rdata = r_hi_snap;
         A_CMP_L:   w_rdata = r_cmp[31:0];
         A_CMP_H:   w_rdata = r_cmp[63:32];
         default:   w_rdata = 32'd0;
      endcase
   end

   // State registers, synchronous reset overrides everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_en       <= 1'b0;
         r_ie       <= 1'b0;
         r_per      <= 1'b0;
         r_pend     <= 1'b0;
         r_presc    <= '0;
         r_pcnt     <= '0;
         r_mtime    <= 64'd0;
         r_cmp      <= CMP_RST;
         r_hi_snap  <= 32'd0;
         r_data_out <= 32'd0;
         r_irq      <= 1'b0;
      end else begin
         r_pcnt  <= w_pcnt_nxt;
         r_mtime <= w_mtime_nxt;
         r_pend  <= w_pend_nxt;
         r_ie    <= w_ie_nxt;
         r_irq   <= w_pend_nxt & w_ie_nxt;
         if (w_we && i_addr == A_CTRL) begin
            r_en  <= i_data_in[0];
            r_per <= i_data_in[2];
         end
         if (w_we && i_addr == A_PRESC)
            r_presc <= i_data_in[PRESC_W-1:0];
         if (w_we && i_addr == A_CMP_L)
            r_cmp[31:0] <= i_data_in;
         if (w_we && i_addr == A_CMP_H)
            r_cmp[63:32] <= i_data_in;
         if (w_re) begin
            r_data_out <= w_rdata;
            if (i_addr == A_MTIME_L)
               r_hi_snap <= r_mtime[63:32];
         end
      end
   end

   assign o_data_out = r_data_out;
   assign o_irq      = r_irq;

endmodule

// File: tb/tb_timer_regs.sv
// Directed plus randomized bench for timer_regs against a behavioural model.
module tb_timer_regs;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_wr = 1'b0;
   logic        i_rd = 1'b0;
   logic        i_cs = 1'b0;
   logic [2:0]  i_addr = 3'd0;
   logic [31:0] i_data_in = 32'd0;
   logic [31:0] o_data_out;
   logic        o_irq;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          m_en, m_ie, m_per, m_pend, m_irq;
   int unsigned m_presc, m_pcnt;
   logic [63:0] m_mtime, m_cmp;
   logic [31:0] m_snap, m_out;

   timer_regs dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_wr), .i_rd(i_rd), .i_cs(i_cs),
      .i_addr(i_addr), .i_data_in(i_data_in), .o_data_out(o_data_out), .o_irq(o_irq)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance model, compare outputs after the edge.
   task automatic step(input bit rst, input bit cs, input bit wr, input bit rd,
                       input logic [2:0] addr, input logic [31:0] data);
      bit          match, tick, we, re;
      logic [63:0] t;
      i_rst = rst; i_cs = cs; i_wr = wr; i_rd = rd; i_addr = addr; i_data_in = data;
      we = cs && wr;
      re = cs && rd;
      @(posedge i_clk);
      if (rst) begin
         {m_en, m_ie, m_per, m_pend, m_irq} = '0;
         m_presc = 0; m_pcnt = 0; m_mtime = 0; m_cmp = '1; m_snap = 0; m_out = 0;
      end else begin
         match = (m_mtime >= m_cmp);
         tick  = m_en && (m_pcnt == 0);
         if (re) begin
            case (addr)
               3'd0: m_out = {28'd0, m_pend, m_per, m_ie, m_en};
               3'd1: m_out = m_presc;
               3'd2: m_out = m_mtime[31:0];
               3'd3: m_out = m_snap;
               3'd4: m_out = m_cmp[31:0];
               3'd5: m_out = m_cmp[63:32];
               default: m_out = 0;
            endcase
            if (addr == 3'd2) m_snap = m_mtime[63:32];
         end
         t = m_mtime;
         if (tick) t = (m_per && match) ? 64'd0 : m_mtime + 1;
         if (m_en) m_pcnt = (m_pcnt == 0) ? m_presc : m_pcnt - 1;
         if (m_pend && we && addr == 3'd0 && data[3]) m_pend = 0;
         if (match) m_pend = 1;
         if (we) begin
            case (addr)
               3'd0: begin m_en = data[0]; m_ie = data[1]; m_per = data[2]; end
               3'd1: begin m_presc = data % 65536; m_pcnt = m_presc; end
               3'd2: t = {m_mtime[63:32], data};
               3'd3: t = {data, m_mtime[31:0]};
               3'd4: m_cmp[31:0] = data;
               3'd5: m_cmp[63:32] = data;
               default: ;
            endcase
         end
         m_mtime = t;
         m_irq = m_pend && m_ie;
      end
      #1;
      chk("dout", {32'd0, o_data_out}, {32'd0, m_out});
      chk("irq", {63'd0, o_irq}, {63'd0, m_irq});
   endtask

   task automatic rd(input logic [2:0] a);
      step(0, 1, 0, 1, a, 32'd0);
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      step(0, 1, 1, 0, a, d);
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 3'd0, 32'd0);
   endtask
   task automatic do_reset();
      step(1, 0, 0, 0, 3'd0, 32'd0);
      step(1, 1, 1, 1, 3'd2, 32'hDEAD_BEEF);
   endtask

   initial begin
      int v;
      bit seen;
      @(negedge i_clk);

      // Reset values
      do_reset();
      chk("rst_dout", {32'd0, o_data_out}, 64'd0);
      chk("rst_irq", {63'd0, o_irq}, 64'd0);
      rd(0); chk("rst_ctrl", {32'd0, o_data_out}, 64'd0);
      rd(1); chk("rst_presc", {32'd0, o_data_out}, 64'd0);
      rd(2); chk("rst_mlo", {32'd0, o_data_out}, 64'd0);
      rd(3); chk("rst_mhi", {32'd0, o_data_out}, 64'd0);
      rd(4); chk("rst_clo", {32'd0, o_data_out}, 64'hFFFF_FFFF);
      rd(5); chk("rst_chi", {32'd0, o_data_out}, 64'hFFFF_FFFF);
      rd(6); chk("rst_a6", {32'd0, o_data_out}, 64'd0);

      // Prescaler rate and freeze
      wr(1, 32'd3);
      wr(0, 32'd1);
      idle(40);
      rd(2);
      v = o_data_out;
      chk("presc_rate", {63'd0, (v >= 9 && v <= 11)}, 64'd1);
      wr(0, 32'd0);
      idle(20);
      rd(2); chk("freeze", {32'd0, o_data_out}, 64'd10);

      // PRESC width and rd+wr returning old value
      wr(1, 32'hFFFF_1234);
      rd(1); chk("presc_w", {32'd0, o_data_out}, 64'h1234);
      step(0, 1, 1, 1, 3'd1, 32'd7);
      chk("rdwr_old", {32'd0, o_data_out}, 64'h1234);
      rd(1); chk("rdwr_new", {32'd0, o_data_out}, 64'd7);
      wr(7, 32'hFFFF_FFFF);
      rd(7); chk("a7_zero", {32'd0, o_data_out}, 64'd0);

      // Compare and interrupt
      do_reset();
      wr(5, 32'd0); wr(4, 32'd5); wr(1, 32'd0); wr(0, 32'd3);
      seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         idle(1);
         seen = o_irq;
      end
      chk("irq_rise", {63'd0, seen}, 64'd1);
      wr(0, 32'hB);
      rd(0); chk("pend_sticky", {63'd0, o_data_out[3]}, 64'd1);
      wr(5, 32'hFFFF_FFFF);
      wr(0, 32'hB);
      chk("irq_clear", {63'd0, o_irq}, 64'd0);
      rd(0); chk("pend_clear", {63'd0, o_data_out[3]}, 64'd0);

      // Periodic mode
      do_reset();
      wr(5, 32'd0); wr(4, 32'd4); wr(0, 32'd5);
      for (int k = 0; k < 15; k++) begin
         rd(2);
         chk("per_range", {63'd0, (o_data_out <= 32'd4)}, 64'd1);
      end
      rd(0); chk("per_pend", {63'd0, o_data_out[3]}, 64'd1);

      // Coherent read across the 32-bit boundary
      do_reset();
      wr(3, 32'd0); wr(2, 32'hFFFF_FFFE); wr(0, 32'd1);
      rd(2); chk("coh_lo", {32'd0, o_data_out}, 64'hFFFF_FFFE);
      idle(3);
      rd(3); chk("coh_hi", {32'd0, o_data_out}, 64'd0);
      rd(2); rd(3); chk("coh_hi2", {32'd0, o_data_out}, 64'd1);

      // 64-bit wrap
      wr(0, 32'd0);
      wr(3, 32'hFFFF_FFFF); wr(2, 32'hFFFF_FFFF);
      wr(0, 32'd1); wr(0, 32'd0);
      rd(2); chk("wrap_lo", {32'd0, o_data_out}, 64'd0);
      rd(3); chk("wrap_hi", {32'd0, o_data_out}, 64'd0);

      // Write colliding with a tick
      wr(3, 32'd0);
      wr(0, 32'd1);
      wr(2, 32'h100);
      wr(0, 32'd0);
      rd(2); chk("collide", {32'd0, o_data_out}, 64'h101);
      rd(3); chk("collide_hi", {32'd0, o_data_out}, 64'd0);

      // Randomized traffic
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         logic [31:0] d;
         d = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom;
         if ($urandom_range(0, 4) == 0) d[31:4] = '1;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0,
              3'($urandom_range(0, 7)), d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
